// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       N;
  logic       V;
  logic       C;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, N, V, C, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, N, V, C, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: steps fetch/decode/execute/
// memory/writeback and drives all datapath enables and mux selects.
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND   = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR   = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLT   = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLL   = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRL   = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRA   = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_PASSB = 4'b1111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;

  state_t state, state_next;

  logic             pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
  logic [1:0]       result_src_c, alu_src_a_c, alu_src_b_c;
  logic [2:0]       imm_src_c;
  logic [ALU_W-1:0] alu_control_c;
  logic             instr_done_c, illegal_c;
  logic             branch_taken_c;

  // ALU operation from funct3; sub_ok lets funct7b5 select sub (R-type only).
  function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3,
                                                  input logic sub_ok,
                                                  input logic f7b5);
    case (f3)
      3'b000:  alu_decode = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (bus.funct3)
      3'b000:  branch_taken_c = bus.Zero;
      3'b001:  branch_taken_c = !bus.Zero;
      3'b100:  branch_taken_c = bus.N ^ bus.V;
      3'b101:  branch_taken_c = !(bus.N ^ bus.V);
      3'b110:  branch_taken_c = !bus.C;
      3'b111:  branch_taken_c = bus.C;
      default: branch_taken_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write_c    = 1'b0;
    adr_src_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    result_src_c  = 2'b00;
    alu_src_a_c   = 2'b00;
    alu_src_b_c   = 2'b00;
    imm_src_c     = 3'b000;
    alu_control_c = ALU_ADD;
    instr_done_c  = 1'b0;
    illegal_c     = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        pc_write_c   = bus.MemReady;
        ir_write_c   = bus.MemReady;
        if (bus.MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        imm_src_c   = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = (bus.funct3[2:1] == 2'b01) ?
                                          (ILLEGAL_HALT ? S_ILLEGAL : S_FETCH) : S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        imm_src_c   = bus.op[5] ? 3'b001 : 3'b000;
        state_next  = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        if (bus.MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c    = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = bus.MemReady;
        if (bus.MemReady) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = alu_decode(bus.funct3, 1'b1, bus.funct7b5);
        state_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_c   = 2'b10;
        alu_src_b_c   = 2'b01;
        alu_control_c = alu_decode(bus.funct3, 1'b0, bus.funct7b5);
        state_next    = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b_c   = 2'b01;
        imm_src_c     = 3'b100;
        alu_control_c = ALU_PASSB;
        state_next    = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        imm_src_c   = 3'b100;
        state_next  = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = ALU_SUB;
        pc_write_c    = branch_taken_c;
        instr_done_c  = 1'b1;
        state_next    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_c  = 1'b1;
        state_next = S_ILLEGAL;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset gates every write enable immediately, even mid-instruction.
    if (reset) begin
      pc_write_c   = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      mem_write_c  = 1'b0;
      instr_done_c = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write_c;
  assign bus.AdrSrc     = adr_src_c;
  assign bus.MemWrite   = mem_write_c;
  assign bus.IRWrite    = ir_write_c;
  assign bus.RegWrite   = reg_write_c;
  assign bus.ResultSrc  = result_src_c;
  assign bus.ALUSrcA    = alu_src_a_c;
  assign bus.ALUSrcB    = alu_src_b_c;
  assign bus.ImmSrc     = imm_src_c;
  assign bus.ALUControl = alu_control_c;
  assign bus.InstrDone  = instr_done_c;
  assign bus.Illegal    = illegal_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control
// vectors are queued with the stimulus and compared at the falling edge.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op_r;
  logic [2:0] f3_r;
  logic f7_r, zero_r, n_r, v_r, c_r, mr_r;

  always #5 clk = ~clk;

  multicycle_controller_if if1 ();
  multicycle_controller_if if2 ();

  assign if1.op = op_r;    assign if2.op = op_r;
  assign if1.funct3 = f3_r; assign if2.funct3 = f3_r;
  assign if1.funct7b5 = f7_r; assign if2.funct7b5 = f7_r;
  assign if1.Zero = zero_r; assign if2.Zero = zero_r;
  assign if1.N = n_r;      assign if2.N = n_r;
  assign if1.V = v_r;      assign if2.V = v_r;
  assign if1.C = c_r;      assign if2.C = c_r;
  assign if1.MemReady = mr_r; assign if2.MemReady = mr_r;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_halt (.clk(clk), .reset(reset), .bus(if1));
  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_skip (.clk(clk), .reset(reset), .bus(if2));

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,InstrDone,Illegal}
  logic [19:0] obs1, obs2;
  assign obs1 = {if1.PCWrite, if1.AdrSrc, if1.MemWrite, if1.IRWrite, if1.RegWrite, if1.ResultSrc,
                 if1.ALUSrcA, if1.ALUSrcB, if1.ImmSrc, if1.ALUControl, if1.InstrDone, if1.Illegal};
  assign obs2 = {if2.PCWrite, if2.AdrSrc, if2.MemWrite, if2.IRWrite, if2.RegWrite, if2.ResultSrc,
                 if2.ALUSrcA, if2.ALUSrcB, if2.ImmSrc, if2.ALUControl, if2.InstrDone, if2.Illegal};

  typedef struct {
    logic        mr;
    logic [19:0] e1;
    logic [19:0] e2;
    string       tag;
  } ent_t;

  ent_t sb[$];
  ent_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [19:0] ev(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sbsel,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic done, ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sbsel, imm, alu, done, ill};
  endfunction

  function automatic logic [19:0] x_fetch(input logic mr);
    return ev(mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 1'b0, 1'b0);
  endfunction
  function automatic logic [19:0] x_decode(input logic is_jal);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, is_jal ? 3'b011 : 3'b010, 4'h0, 1'b0, 1'b0);
  endfunction
  function automatic logic [19:0] x_aluwb();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b1, 1'b0);
  endfunction

  function automatic void push(input string tag, input logic mr, input logic [19:0] e1, input logic [19:0] e2);
    ent_t e;
    e.tag = tag; e.mr = mr; e.e1 = e1; e.e2 = e2;
    sb.push_back(e);
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op_r = o; f3_r = f3; f7_r = f7;
  endtask

  task automatic test_reset();
    reset = 1'b1; mr_r = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    zero_r = 1'b0; n_r = 1'b0; v_r = 1'b0; c_r = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs1 !== x_fetch(1'b0)) begin
      n_fail++; $display("FAIL reset_hold halt=1: got %05h want %05h", obs1, x_fetch(1'b0));
    end
    n_checks++;
    if (obs2 !== x_fetch(1'b0)) begin
      n_fail++; $display("FAIL reset_hold halt=0: got %05h want %05h", obs2, x_fetch(1'b0));
    end
    mr_r = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs1 !== x_fetch(1'b0)) begin
      n_fail++; $display("FAIL reset_release: got %05h want %05h", obs1, x_fetch(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_add();
    set_instr(7'b0110011, 3'b000, 1'b0);
    push("add_fetch", 1'b1, x_fetch(1'b1), x_fetch(1'b1));
    push("add_decode", 1'b0, x_decode(1'b0), x_decode(1'b0));
    push("add_exec", 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'h0,0,0), ev(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'h0,0,0));
    push("add_wb", 1'b0, x_aluwb(), x_aluwb());
    push("add_next", 1'b0, x_fetch(1'b0), x_fetch(1'b0));
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      mr_r = cur.mr;
      @(negedge clk);
      n_checks++;
      if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
      n_checks++;
      if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [19:0] mrd, mwb, madr;
    set_instr(7'b0000011, 3'b010, 1'b0);
    madr = ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'h0,0,0);
    mrd  = ev(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'h0,0,0);
    mwb  = ev(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'h0,1,0);
    push("lw_fetch", 1'b1, x_fetch(1'b1), x_fetch(1'b1));
    push("lw_decode", 1'b0, x_decode(1'b0), x_decode(1'b0));
    push("lw_memadr", 1'b0, madr, madr);
    push("lw_memread_w0", 1'b0, mrd, mrd);
    push("lw_memread_w1", 1'b0, mrd, mrd);
    push("lw_memread_rdy", 1'b1, mrd, mrd);
    push("lw_memwb", 1'b0, mwb, mwb);
    push("lw_next", 1'b0, x_fetch(1'b0), x_fetch(1'b0));
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      mr_r = cur.mr;
      @(negedge clk);
      n_checks++;
      if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
      n_checks++;
      if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    // {funct3, Zero, N, V, C, taken}
    logic [7:0] tbl [5];
    logic [19:0] br;
    tbl[0] = {3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = {3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = {3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = {3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      set_instr(7'b1100011, tbl[k][7:5], 1'b0);
      zero_r = tbl[k][4]; n_r = tbl[k][3]; v_r = tbl[k][2]; c_r = tbl[k][1];
      br = ev(tbl[k][0],0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,1,0);
      push($sformatf("br%0d_fetch", k), 1'b1, x_fetch(1'b1), x_fetch(1'b1));
      push($sformatf("br%0d_decode", k), 1'b0, x_decode(1'b0), x_decode(1'b0));
      push($sformatf("br%0d_branch", k), 1'b0, br, br);
      push($sformatf("br%0d_next", k), 1'b0, x_fetch(1'b0), x_fetch(1'b0));
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        mr_r = cur.mr;
        @(negedge clk);
        n_checks++;
        if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
        n_checks++;
        if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
        @(posedge clk); #1;
      end
    end
    zero_r = 1'b0; n_r = 1'b0; v_r = 1'b0; c_r = 1'b0;
  endtask

  task automatic test_alu_decode();
    // {op, funct3, f7b5, srcB, ALUControl}
    logic [6:0] ops [3];
    logic [2:0] f3s [3];
    logic       f7s [3];
    logic [1:0] sbs [3];
    logic [3:0] alus [3];
    logic [19:0] ex;
    ops[0] = 7'b0010011; f3s[0] = 3'b101; f7s[0] = 1'b1; sbs[0] = 2'b01; alus[0] = 4'b1001;
    ops[1] = 7'b0010011; f3s[1] = 3'b000; f7s[1] = 1'b1; sbs[1] = 2'b01; alus[1] = 4'b0000;
    ops[2] = 7'b0110011; f3s[2] = 3'b000; f7s[2] = 1'b1; sbs[2] = 2'b00; alus[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      set_instr(ops[k], f3s[k], f7s[k]);
      ex = ev(0,0,0,0,0,2'b00,2'b10,sbs[k],3'b000,alus[k],0,0);
      push($sformatf("alu%0d_fetch", k), 1'b1, x_fetch(1'b1), x_fetch(1'b1));
      push($sformatf("alu%0d_decode", k), 1'b0, x_decode(1'b0), x_decode(1'b0));
      push($sformatf("alu%0d_exec", k), 1'b0, ex, ex);
      push($sformatf("alu%0d_wb", k), 1'b0, x_aluwb(), x_aluwb());
      push($sformatf("alu%0d_next", k), 1'b0, x_fetch(1'b0), x_fetch(1'b0));
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        mr_r = cur.mr;
        @(negedge clk);
        n_checks++;
        if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
        n_checks++;
        if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_upper_jump();
    logic [6:0]  ops [3];
    logic [19:0] exs [3];
    ops[0] = 7'b0110111; exs[0] = ev(0,0,0,0,0,2'b00,2'b00,2'b01,3'b100,4'b1111,0,0);
    ops[1] = 7'b0010111; exs[1] = ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,4'b0000,0,0);
    ops[2] = 7'b1101111; exs[2] = ev(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,4'b0000,0,0);
    for (int k = 0; k < 3; k++) begin
      set_instr(ops[k], 3'b000, 1'b0);
      push($sformatf("uj%0d_fetch", k), 1'b1, x_fetch(1'b1), x_fetch(1'b1));
      push($sformatf("uj%0d_decode", k), 1'b0, x_decode(k == 2), x_decode(k == 2));
      push($sformatf("uj%0d_exec", k), 1'b0, exs[k], exs[k]);
      push($sformatf("uj%0d_wb", k), 1'b0, x_aluwb(), x_aluwb());
      push($sformatf("uj%0d_next", k), 1'b0, x_fetch(1'b0), x_fetch(1'b0));
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        mr_r = cur.mr;
        @(negedge clk);
        n_checks++;
        if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
        n_checks++;
        if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    logic [19:0] ill;
    ill = ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'h0,0,1);
    set_instr(7'b0000000, 3'b000, 1'b0);
    push("ill_fetch", 1'b1, x_fetch(1'b1), x_fetch(1'b1));
    push("ill_decode", 1'b0, x_decode(1'b0), x_decode(1'b0));
    for (int k = 0; k < 11; k++) push($sformatf("ill_park%0d", k), 1'b0, ill, x_fetch(1'b0));
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      mr_r = cur.mr;
      @(negedge clk);
      n_checks++;
      if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
      n_checks++;
      if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midwrite();
    logic [19:0] madr, mwr;
    madr = ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'h0,0,0);
    mwr  = ev(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,4'h0,0,0);
    mr_r = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    set_instr(7'b0100011, 3'b010, 1'b0);
    push("sw_fetch", 1'b1, x_fetch(1'b1), x_fetch(1'b1));
    push("sw_decode", 1'b0, x_decode(1'b0), x_decode(1'b0));
    push("sw_memadr", 1'b0, madr, madr);
    push("sw_memwrite_w0", 1'b0, mwr, mwr);
    push("sw_memwrite_w1", 1'b0, mwr, mwr);
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      mr_r = cur.mr;
      @(negedge clk);
      n_checks++;
      if (obs1 !== cur.e1) begin n_fail++; $display("FAIL %s halt=1: got %05h want %05h", cur.tag, obs1, cur.e1); end
      n_checks++;
      if (obs2 !== cur.e2) begin n_fail++; $display("FAIL %s halt=0: got %05h want %05h", cur.tag, obs2, cur.e2); end
      @(posedge clk); #1;
    end
    // Still in MEMWRITE with MemReady low; reset lands in the same low phase.
    @(negedge clk);
    n_checks++;
    if (if1.MemWrite !== 1'b1) begin n_fail++; $display("FAIL sw_pre_reset MemWrite: got %b want 1", if1.MemWrite); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (if1.MemWrite !== 1'b0) begin n_fail++; $display("FAIL sw_reset_drop MemWrite: got %b want 0", if1.MemWrite); end
    n_checks++;
    if (obs1 !== x_fetch(1'b0)) begin n_fail++; $display("FAIL sw_reset_vec: got %05h want %05h", obs1, x_fetch(1'b0)); end
    mr_r = 1'b1;
    #1;
    n_checks++;
    if (if1.PCWrite !== 1'b0) begin n_fail++; $display("FAIL sw_reset_pcw: got %b want 0", if1.PCWrite); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs1 !== x_fetch(1'b1)) begin n_fail++; $display("FAIL post_reset_fetch: got %05h want %05h", obs1, x_fetch(1'b1)); end
    n_checks++;
    if (obs2 !== x_fetch(1'b1)) begin n_fail++; $display("FAIL post_reset_fetch halt=0: got %05h want %05h", obs2, x_fetch(1'b1)); end
    mr_r = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_load_wait();
    test_branch();
    test_alu_decode();
    test_upper_jump();
    test_illegal();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
